// File: rtl/moisture_sampler_pkg.sv
// rtl/moisture_sampler_pkg.sv - shared types and constants for the moisture sampler
//
// Purpose:
//   Burst FSM state encoding, the sample/m_sense data width and a
//   counter-width helper shared by the moisture sampler and its
//   seconds-period counter.
// Ports:
//   none (package)

package moisture_sampler_pkg;

  // Width of adc_data and m_sense.
  localparam int DATA_W = 7;

  // Burst FSM states: IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Bits needed to count 0..n-1. A modulo-1 counter still gets one bit
  // so that no vector ever collapses to zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/moisture_sampler_sec_period_counter.sv
// rtl/moisture_sampler_sec_period_counter.sv - sec_tick-driven modulo counter issuing burst_go
//
// Purpose:
//   Counts seconds modulo PERIOD and marks the tick on which a new burst
//   should start (the tick taken while the count is zero). The counter
//   advances on every sec_tick whatever the burst FSM is doing, so the
//   burst cadence never drifts because of a slow ADC.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset (count -> 0)
//   sec_tick  in   1-cycle pulse once per second
//   burst_go  out  combinational: sec_tick arrived while the count is 0

module sec_period_counter
  import moisture_sampler_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sec_tick,
  output logic burst_go
);

  localparam int              CW   = cnt_width(PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

  logic [CW-1:0] period_cnt;

  // The first tick after reset sees period_cnt == 0, so the first burst
  // starts immediately rather than one full period later.
  assign burst_go = sec_tick && (period_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (sec_tick) begin
      if (period_cnt == LAST) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/moisture_sampler.sv
// rtl/moisture_sampler.sv - burst-averaging ADC sampler producing m_sense
//
// Purpose:
//   Every SAMPLE_PERIOD_S seconds runs a burst of 2^AVG_LOG2 ADC
//   conversions, averages them (truncating) and publishes the result on
//   m_sense with a one-cycle m_sense_valid strobe. A conversion that is
//   not answered within TIMEOUT_CYC cycles abandons the burst and raises
//   the sticky sensor_fault flag; the next successful burst clears it.
// Ports:
//   clk            in   32768 Hz system clock
//   rst            in   synchronous, active-high reset
//   sec_tick       in   1-cycle pulse once per second
//   adc_start      out  1-cycle conversion request
//   adc_done       in   1-cycle pulse, adc_data valid this cycle
//   adc_data       in   conversion result (DATA_W bits)
//   m_sense        out  averaged moisture, held between updates
//   m_sense_valid  out  1-cycle pulse when m_sense updates
//   sensor_fault   out  high after a timed-out burst until a good one

module moisture_sampler
  import moisture_sampler_pkg::*;
#(
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLE_PERIOD_S = 10,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] m_sense,
  output logic              m_sense_valid,
  output logic              sensor_fault
);

  // The accumulator holds at most 2^AVG_LOG2 full-scale samples, so
  // DATA_W+AVG_LOG2 bits can never overflow.
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int SC_W  = AVG_LOG2 + 1;
  localparam int TO_W  = cnt_width(TIMEOUT_CYC + 1);

  localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

  state_t            state;
  state_t            state_n;
  logic              burst_go;
  logic [ACC_W-1:0]  acc;
  logic [SC_W-1:0]   sample_cnt;
  logic [TO_W-1:0]   timeout_cnt;
  logic              last_sample;
  logic              timed_out;

  sec_period_counter #(
    .PERIOD (SAMPLE_PERIOD_S)
  ) u_period (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .burst_go (burst_go)
  );

  // timeout_cnt is 0 in the first WAIT cycle, so reaching TO_LAST means
  // this is the TIMEOUT_CYC-th cycle spent waiting. A done in that same
  // cycle still counts as an answer.
  assign last_sample = (sample_cnt == LAST_SAMPLE);
  assign timed_out   = (state == S_WAIT) && !adc_done && (timeout_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and the Moore conversion request. burst_go is looked at
  // only in IDLE: a start that lands mid-burst is simply dropped.
  always_comb begin
    state_n   = state;
    adc_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (burst_go) begin
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        adc_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          state_n = last_sample ? S_DONE : S_REQ;
        end else if (timed_out) begin
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath: accumulator, sample and timeout counters, published outputs.
  // adc_done is only sampled in WAIT, which also rejects a done that
  // arrives in the same cycle as adc_start (state is REQ then).
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      sample_cnt    <= '0;
      timeout_cnt   <= '0;
      m_sense       <= {DATA_W{1'b1}};
      m_sense_valid <= 1'b0;
      sensor_fault  <= 1'b0;
    end else begin
      m_sense_valid <= 1'b0;
      case (state)
        S_REQ: begin
          timeout_cnt <= '0;
        end
        S_WAIT: begin
          if (adc_done) begin
            acc        <= acc + ACC_W'(adc_data);
            sample_cnt <= sample_cnt + SC_W'(1);
          end else if (timed_out) begin
            // Abandon the burst; m_sense keeps its last good value.
            sensor_fault <= 1'b1;
            acc          <= '0;
            sample_cnt   <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end
        S_DONE: begin
          m_sense       <= acc[ACC_W-1:AVG_LOG2];
          m_sense_valid <= 1'b1;
          sensor_fault  <= 1'b0;
          acc           <= '0;
          sample_cnt    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moisture_sampler.sv
// tb/tb_moisture_sampler.sv - self-checking bench for moisture_sampler

module tb_moisture_sampler;

  localparam int NS  = 4;
  localparam int P_A = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick_a, done_a, start_a, valid_a, fault_a;
  logic [6:0] data_a, m_a;
  logic       sec_tick_b, done_b, start_b, valid_b, fault_b;
  logic [6:0] data_b, m_b;

  int checks   = 0;
  int failures = 0;

  int starts_a = 0, valids_a = 0, starts_b = 0, valids_b = 0;

  int cnt_a       = 0;
  int exp_m_a     = 127;
  int exp_fault_a = 0;
  int exp_m_b     = 127;
  int vals[NS];
  int dels[NS];

  always #5 clk = ~clk;

  moisture_sampler #(
    .AVG_LOG2(2), .SAMPLE_PERIOD_S(P_A), .TIMEOUT_CYC(255)
  ) dut_a (
    .clk(clk), .rst(rst), .sec_tick(sec_tick_a), .adc_start(start_a),
    .adc_done(done_a), .adc_data(data_a), .m_sense(m_a),
    .m_sense_valid(valid_a), .sensor_fault(fault_a)
  );

  moisture_sampler #(
    .AVG_LOG2(2), .SAMPLE_PERIOD_S(1), .TIMEOUT_CYC(255)
  ) dut_b (
    .clk(clk), .rst(rst), .sec_tick(sec_tick_b), .adc_start(start_b),
    .adc_done(done_b), .adc_data(data_b), .m_sense(m_b),
    .m_sense_valid(valid_b), .sensor_fault(fault_b)
  );

  // Pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (start_a === 1'b1) starts_a++;
    if (valid_a === 1'b1) valids_a++;
    if (start_b === 1'b1) starts_b++;
    if (valid_b === 1'b1) valids_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Second boundaries for instance A; the model decides whether this tick
  // opens a burst.
  task automatic pulse_tick_a(output bit go);
    go    = (cnt_a == 0);
    cnt_a = (cnt_a == P_A - 1) ? 0 : cnt_a + 1;
    sec_tick_a = 1'b1;
    @(negedge clk);
    sec_tick_a = 1'b0;
  endtask

  task automatic start_burst_a();
    bit go;
    go = 1'b0;
    while (!go) begin
      pulse_tick_a(go);
      if (!go) begin
        chk("a_no_start_off_period", start_a, 0);
        cyc(1);
      end
    end
    chk("a_start_on_period", start_a, 1);
  endtask

  // Answer one conversion request d cycles after it is seen. With early
  // set, a bogus done (data 127) is also driven alongside adc_start.
  task automatic serve_a(input int v, input int d, input bit early);
    int n;
    n = 0;
    while (start_a !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("a_start_seen", (n < 3000), 1);
    if (early) begin
      done_a = 1'b1; data_a = 7'h7f;
      @(negedge clk);
      done_a = 1'b0; data_a = 7'($urandom);
      repeat (d - 1) @(negedge clk);
    end else begin
      repeat (d) @(negedge clk);
    end
    done_a = 1'b1; data_a = 7'(v);
    @(negedge clk);
    done_a = 1'b0; data_a = 7'($urandom);
  endtask

  task automatic run_burst_a(input string tag, input bit early);
    int s0, v0, sum;
    s0 = starts_a;
    v0 = valids_a;
    start_burst_a();
    chk({tag, "_fault_before"}, fault_a, exp_fault_a);
    sum = 0;
    for (int i = 0; i < NS; i++) begin
      serve_a(vals[i], dels[i], early && (i == 0));
      sum += vals[i];
    end
    exp_m_a     = sum / NS;
    exp_fault_a = 0;
    chk({tag, "_valid_not_yet"}, valid_a, 0);
    cyc(1);
    chk({tag, "_valid"}, valid_a, 1);
    chk({tag, "_m_sense"}, m_a, exp_m_a);
    chk({tag, "_fault_clear"}, fault_a, 0);
    cyc(1);
    chk({tag, "_valid_width"}, valid_a, 0);
    chk({tag, "_m_sense_held"}, m_a, exp_m_a);
    chk({tag, "_start_count"}, starts_a - s0, NS);
    chk({tag, "_valid_count"}, valids_a - v0, 1);
  endtask

  task automatic set_vals(input int a, input int b, input int c, input int d, input int dl);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    for (int i = 0; i < NS; i++) dels[i] = dl;
  endtask

  initial begin
    int s0, v0, n, sum;
    rst = 1'b1;
    sec_tick_a = 1'b0; done_a = 1'b0; data_a = '0;
    sec_tick_b = 1'b0; done_b = 1'b0; data_b = '0;
    cyc(3);
    chk("rst_a_start", start_a, 0);
    chk("rst_a_valid", valid_a, 0);
    chk("rst_a_fault", fault_a, 0);
    chk("rst_a_m_sense", m_a, 127);
    chk("rst_b_start", start_b, 0);
    chk("rst_b_m_sense", m_b, 127);
    rst = 1'b0;
    cyc(2);

    // First burst on the first tick, ADC answering 3 cycles after each start.
    set_vals(40, 41, 42, 43, 3);
    run_burst_a("t1", 1'b0);
    chk("t1_m_sense_41", m_a, 41);

    // Full scale and truncation.
    set_vals(127, 127, 127, 127, 2);
    run_burst_a("t2_full", 1'b0);
    set_vals(0, 0, 0, 3, 1);
    run_burst_a("t2_trunc", 1'b0);

    // Random bursts.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NS; i++) begin
        vals[i] = int'($urandom_range(0, 127));
        dels[i] = int'($urandom_range(1, 6));
      end
      run_burst_a("t2_rand", 1'b0);
    end

    // Dead ADC: fault after 255 WAIT cycles, m_sense untouched.
    s0 = starts_a;
    v0 = valids_a;
    start_burst_a();
    n = 0;
    while (fault_a !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    exp_fault_a = 1;
    chk("t3_timeout_cycles", n, 256);
    chk("t3_m_sense_held", m_a, exp_m_a);
    chk("t3_no_valid", valids_a - v0, 0);
    chk("t3_one_start", starts_a - s0, 1);
    cyc(3);
    chk("t3_back_idle", start_a, 0);
    chk("t3_fault_sticky", fault_a, 1);

    // Answer on the very last permitted WAIT cycle: done beats the timeout.
    for (int i = 0; i < NS; i++) vals[i] = int'($urandom_range(0, 127));
    dels[0] = 255; dels[1] = 2; dels[2] = 2; dels[3] = 2;
    run_burst_a("t3_recover", 1'b0);

    // Reset after two of four samples.
    start_burst_a();
    serve_a(120, 2, 1'b0);
    serve_a(121, 2, 1'b0);
    rst = 1'b1;
    cyc(1);
    cnt_a = 0; exp_m_a = 127; exp_fault_a = 0;
    chk("t4_rst_start", start_a, 0);
    chk("t4_rst_valid", valid_a, 0);
    chk("t4_rst_fault", fault_a, 0);
    chk("t4_rst_m_sense", m_a, 127);
    rst = 1'b0;
    cyc(2);
    for (int i = 0; i < NS; i++) begin
      vals[i] = int'($urandom_range(0, 20));
      dels[i] = 2;
    end
    run_burst_a("t4_fresh", 1'b0);

    // Spurious done while idle, then a done coinciding with adc_start.
    done_a = 1'b1; data_a = 7'h7f;
    cyc(1);
    done_a = 1'b0;
    cyc(2);
    chk("t5_idle_done_no_valid", valid_a, 0);
    for (int i = 0; i < NS; i++) begin
      vals[i] = int'($urandom_range(0, 60));
      dels[i] = 3;
    end
    run_burst_a("t5_ignored", 1'b1);

    // Instance B: one-second period, bursts longer than a second.
    s0 = starts_b;
    v0 = valids_b;
    for (int k = 0; k < 2; k++) begin
      sec_tick_b = 1'b1;
      cyc(1);
      sec_tick_b = 1'b0;
      chk("t6_start", start_b, 1);
      sum = 0;
      for (int i = 0; i < NS; i++) begin
        int v;
        v = int'($urandom_range(0, 127));
        sum += v;
        n = 0;
        while (start_b !== 1'b1 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("t6_start_seen", (n < 3000), 1);
        sec_tick_b = 1'b1;
        cyc(1);
        sec_tick_b = 1'b0;
        cyc(1);
        sec_tick_b = 1'b1;
        cyc(1);
        sec_tick_b = 1'b0;
        cyc(3);
        done_b = 1'b1; data_b = 7'(v);
        cyc(1);
        done_b = 1'b0; data_b = 7'($urandom);
      end
      exp_m_b = sum / NS;
      sec_tick_b = 1'b1;
      cyc(1);
      sec_tick_b = 1'b0;
      chk("t6_valid", valid_b, 1);
      chk("t6_m_sense", m_b, exp_m_b);
      cyc(5);
      chk("t6_no_queued_start", start_b, 0);
      chk("t6_start_count", starts_b - s0, NS * (k + 1));
    end
    chk("t6_valid_count", valids_b - v0, 2);
    chk("t6_fault", fault_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
